// File: rtl/dual_acc.sv
// dual_acc: dual-lane saturating dot-product accumulator with latency-aligned sideband and 2-entry result FIFO
module dual_acc #(
  parameter int MUL_LAT = 3,
  parameter int ACC_W = 24
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_valid,
  input  logic i_first,
  input  logic i_last,
  input  logic [15:0] i_ac,
  input  logic [15:0] i_bc,
  output logic o_valid,
  input  logic o_ready,
  output logic [ACC_W-1:0] o_acc_a,
  output logic [ACC_W-1:0] o_acc_b,
  output logic o_sat,
  output logic o_busy,
  output logic o_ovf,
  output logic o_seq_err
);
  typedef enum logic {IDLE, ACC} state_t;
  localparam logic [ACC_W-1:0] acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  state_t st, st_nx;
  logic [MUL_LAT-1:0] v_p, f_p, l_p;
  logic v_d, f_d, l_d, first, push, pop, wr, wp, rp;
  logic [1:0] cnt, lsat, lsat_nx, ovr, hold;
  logic [15:0] x [2];
  logic [ACC_W:0] sum [2];
  logic [ACC_W-1:0] acc [2];
  logic [ACC_W-1:0] acc_nx [2];
  logic [2*ACC_W:0] mem [2];
  assign v_d = v_p[MUL_LAT-1];
  assign f_d = f_p[MUL_LAT-1];
  assign l_d = l_p[MUL_LAT-1];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {v_p, f_p, l_p} <= '0;
    end else begin
      for (int k = MUL_LAT - 1; k > 0; k--) begin
        v_p[k] <= v_p[k-1];
        f_p[k] <= f_p[k-1];
        l_p[k] <= l_p[k-1];
      end
      v_p[0] <= i_valid;
      f_p[0] <= i_first & i_valid;
      l_p[0] <= i_last & i_valid;
    end
  end
  always_ff @(posedge clk) st <= !rstn ? IDLE : st_nx;
  always_comb st_nx = v_d ? (l_d ? IDLE : ACC) : st;
  always_comb o_busy = (st == ACC) | (|f_p) | (|l_p);
  always_comb begin
    first = f_d | (st == IDLE);
    x[0] = i_ac;
    x[1] = i_bc;
    for (int n = 0; n < 2; n++) begin
      sum[n] = (first ? '0 : {acc[n][ACC_W-1], acc[n]}) + {{(ACC_W-15){x[n][15]}}, x[n]};
      ovr[n] = sum[n][ACC_W] ^ sum[n][ACC_W-1];
      hold[n] = lsat[n] & ~first;
      acc_nx[n] = hold[n] ? acc[n] : ovr[n] ? (sum[n][ACC_W] ? acc_min : acc_max) : sum[n][ACC_W-1:0];
      lsat_nx[n] = hold[n] | ovr[n];
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '{default: '0};
      lsat <= '0;
      o_seq_err <= 1'b0;
    end else if (v_d) begin
      acc <= acc_nx;
      lsat <= lsat_nx;
      if (f_d == (st == ACC)) o_seq_err <= 1'b1;
    end
  end
  assign push = v_d & l_d;
  assign pop = o_valid & o_ready;
  assign wr = push & (cnt != 2'd2 | pop);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
      o_ovf <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= {|lsat_nx, acc_nx[1], acc_nx[0]};
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, wr} - {1'b0, pop};
      if (push & ~wr) o_ovf <= 1'b1;
    end
  end
  always_comb begin
    o_valid = cnt != 2'd0;
    o_acc_a = o_valid ? mem[rp][ACC_W-1:0] : '0;
    o_acc_b = o_valid ? mem[rp][2*ACC_W-1:ACC_W] : '0;
    o_sat = o_valid & mem[rp][2*ACC_W];
  end
endmodule

// File: doc/dual_acc.md
# dual_acc

Dual-lane accumulator placed directly downstream of the packed INT8 multiplier (`mul`). It consumes the two 16-bit signed partial products `ac` and `bc` each cycle, aligns its own control sideband to the multiplier's DSP latency, and accumulates each lane over a dot-product of arbitrary length delimited by first/last markers. Each completed pair of sums goes into a 2-entry output FIFO with a valid/ready handshake toward the requantization stage. Saturation, overflow and sequencing errors are flagged.

## Interface
- `MUL_LAT`, 3: cycles from multiplier operand issue to `ac`/`bc` valid at this block's inputs; legal range 1..8.
- `ACC_W`, 24: accumulator and output width per lane, signed; legal range 17..32.

- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset. Synchronous and active-low.
- `i_valid`  in  1  operand beat issued to the multiplier this cycle.
- `i_first`  in  1  beat is the first term of a dot-product; qualified by `i_valid`.
- `i_last`  in  1  beat is the last term; qualified by `i_valid`.
- `i_ac`  in  16  signed product, lane A; belongs to the beat issued `MUL_LAT` cycles earlier.
- `i_bc`  in  16  signed product, lane B; same alignment as `i_ac`.
- `o_valid`  out  1  FIFO head holds a result.
- `o_ready`  in  1  consumer accepts head when `o_valid & o_ready`.
- `o_acc_a`  out  ACC_W  lane A sum at FIFO head.
- `o_acc_b`  out  ACC_W  lane B sum at FIFO head.
- `o_sat`  out  1  either lane saturated during the head result's accumulation.
- `o_busy`  out  1  accumulation open, or a marked beat is in the sideband pipe.
- `o_ovf`  out  1  sticky: a result was dropped on a full FIFO.
- `o_seq_err`  out  1  sticky: first/last protocol violation.

## Operation
- Sideband pipe: `{i_valid, i_first & i_valid, i_last & i_valid}` is shifted through `MUL_LAT` registers. Stage outputs `v_d`, `f_d`, `l_d` are aligned with `i_ac`/`i_bc`.
- State machine:
  - IDLE → ACC on `v_d & f_d & ~l_d`.
  - ACC → IDLE on `v_d & l_d`.
- Accumulate on `v_d`, lane by lane. The lane value is `sext(i_xc)` when this is a first term, otherwise `acc + sext(i_xc)`. The result is clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- Once a lane clamps, it holds its clamp value until the next first term. A per-result sat flag is set and travels with the result.
- `v_d` without `f_d` while in IDLE: the beat is treated as a first term and `o_seq_err` is set.
- `f_d` while in ACC: the partial sum is discarded, accumulation restarts with this beat, and `o_seq_err` is set.
- `f_d & l_d` on the same beat: single-term result `{sext(i_ac), sext(i_bc)}` is pushed. State stays or returns IDLE.
- On `v_d & l_d`, the post-add sums plus the sat flag are pushed into the FIFO on the same edge that updates the accumulator.
- FIFO depth is 2:
  - Push when full without a same-cycle pop: the new result is dropped, the FIFO contents are unchanged, and `o_ovf` is set.
  - Push and pop in the same cycle when full: legal, with no drop.
- Outputs `o_acc_*` and `o_sat` reflect the FIFO head. They stay stable while `o_valid & ~o_ready`.
- `o_ovf` and `o_seq_err` clear only on reset.

## Timing
- Reset (`rstn` low at an edge) clears:
  - the sideband pipe, state (to IDLE), accumulators, and FIFO pointers;
  - `o_valid`, `o_acc_a`, `o_acc_b`, `o_sat`, `o_busy`, `o_ovf` and `o_seq_err`, all to 0.
- Reset mid-accumulation or with a non-empty FIFO discards everything. Products arriving in the first `MUL_LAT` cycles after reset release are ignored, because the pipe is cleared.
- Latency: `i_last` beat issued at cycle T → `o_valid` high at T+`MUL_LAT`+1, provided the FIFO is not full.
- Throughput: one term per cycle per lane. Back-to-back dot-products need no gap: `l_d` at cycle N and `f_d` at N+1 are legal.
- `o_valid` deasserts the cycle after the last entry is popped, unless a push occurs in the same cycle.

## Test plan
- Single 4-term dot-product:
  - stimulus: with `MUL_LAT`=3, `i_ac` = 100, −50, 7, 1 and `i_bc` = −1, −2, −3, 32767;
  - required: `o_acc_a`=58, `o_acc_b`=32761, `o_sat`=0;
  - required: `o_valid` rises exactly 4 cycles after the last `i_valid`.
- Saturation:
  - stimulus: with `ACC_W`=17, 5 terms of `i_ac`=32767;
  - required: `o_acc_a`=65535 and `o_sat`=1;
  - required: the next dot-product with a single term 5 gives `o_acc_a`=5, `o_sat`=0.
- Back-pressure:
  - stimulus: hold `o_ready`=0 while three single-term results (1, 2, 3) arrive;
  - required: the FIFO holds 1 and 2, and `o_ovf`=1;
  - required: raising `o_ready` yields 1 then 2, with the head stable while stalled.
- Simultaneous push/pop when full:
  - stimulus: FIFO full, `o_ready`=1 on the same cycle a result 9 is pushed;
  - required: no drop, `o_ovf` stays 0, output order preserved.
- Protocol errors:
  - stimulus: a term without `i_first` while in IDLE;
  - required: the term starts the sum and `o_seq_err`=1;
  - stimulus: `i_first` mid-product (sums 10+20, then first=5, last=6);
  - required: result 11.
- Reset mid-operation:
  - stimulus: drop `rstn` for 1 cycle during an open 3-term product with one result in the FIFO;
  - required: all outputs are 0 the next cycle, no stale result appears, and the next clean product is correct.
